cnn_layer_sequencer: RTL

//  Hardware sequencer for multi-layer CNN inference, replacing CPU-driven per-layer AHB programming and polling.

---
 rtl/cnn_seq_pkg.sv | 55 +++++
 rtl/cnn_layer_sequencer_if.sv | 33 +++
 rtl/cnn_seq_desc_ram.sv | 37 +++
 rtl/cnn_layer_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// rtl/cnn_seq_pkg.sv - shared types, config bit map and address increments for the layer sequencer
// Contents: FSM state encoding, LAYER_CONFIG / descriptor bit positions,
//           weight-base increment helpers and the config word builder.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_t;

  // o_layer_config bit positions; "last" is replicated at bits 1 and 3
  localparam int CFG_FIRST    = 0;
  localparam int CFG_LAST_A   = 1;
  localparam int CFG_CONV     = 2;
  localparam int CFG_LAST_B   = 3;
  localparam int CFG_LIDX_LSB = 4;
  localparam int CFG_BIAS_LSB = 8;
  localparam int CFG_ACT_LSB  = 13;

  // descriptor word: {act[2:0], bias[4:0], conv3x3}
  localparam int DESC_W        = 9;
  localparam int DESC_CONV     = 0;
  localparam int DESC_BIAS_LSB = 1;
  localparam int DESC_ACT_LSB  = 6;

  // weight words consumed by one 3x3 layer: Ti*To*9 taps packed N per line
  function automatic int conv3x3_weight_inc(input int ti, input int to_n, input int n);
    return (ti * to_n * 9) / n;
  endfunction

  function automatic int conv1x1_weight_inc(input int to_n);
    return to_n;
  endfunction

  function automatic logic [31:0] build_cfg(input logic [DESC_W-1:0] desc,
                                            input logic [3:0]        lidx,
                                            input logic              first,
                                            input logic              last);
    logic [31:0] c;
    c                      = '0;
    c[CFG_FIRST]           = first;
    c[CFG_LAST_A]          = last;
    c[CFG_CONV]            = desc[DESC_CONV];
    c[CFG_LAST_B]          = last;
    c[CFG_LIDX_LSB +: 4]   = lidx;
    c[CFG_BIAS_LSB +: 5]   = desc[DESC_BIAS_LSB +: 5];
    c[CFG_ACT_LSB +: 3]    = desc[DESC_ACT_LSB +: 3];
    return c;
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// rtl/cnn_layer_sequencer_if.sv - sequencer <-> accelerator layer handshake bundle
// Signals: o_base_weight/o_base_param (current layer bases), o_layer_config,
//          o_cfg_valid (config load strobe), o_layer_start, i_layer_done (level from accel).
// Modports: master = sequencer side, slave = accelerator side.
interface cnn_layer_sequencer_if #(
  parameter int W_WADDR = 20,
  parameter int W_PADDR = 12
);
  logic [W_WADDR-1:0] o_base_weight;
  logic [W_PADDR-1:0] o_base_param;
  logic [31:0]        o_layer_config;
  logic               o_cfg_valid;
  logic               o_layer_start;
  logic               i_layer_done;

  modport master (
    output o_base_weight,
    output o_base_param,
    output o_layer_config,
    output o_cfg_valid,
    output o_layer_start,
    input  i_layer_done
  );

  modport slave (
    input  o_base_weight,
    input  o_base_param,
    input  o_layer_config,
    input  o_cfg_valid,
    input  o_layer_start,
    output i_layer_done
  );
endinterface

// File: rtl/cnn_seq_desc_ram.sv
// rtl/cnn_seq_desc_ram.sv - per-layer descriptor register file, 1 write / 1 async read
// Ports: clk, rst (sync, active-high, clears all slots), we/waddr/wdata write port,
//        raddr/rdata combinational read port. Out-of-range slots ignore writes and read 0.
module cnn_seq_desc_ram #(
  parameter int MAX_LAYER = 8,
  parameter int W_LIDX    = 4,
  parameter int W_DESC    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [W_LIDX-1:0] waddr,
  input  logic [W_DESC-1:0] wdata,
  input  logic [W_LIDX-1:0] raddr,
  output logic [W_DESC-1:0] rdata
);

  logic [W_DESC-1:0] mem [MAX_LAYER];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAYER; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < MAX_LAYER; i++) begin
        if (waddr == W_LIDX'(i)) mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < MAX_LAYER; i++) begin
      if (raddr == W_LIDX'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - walks a descriptor table, driving one accelerator layer at a time
// Ports: HCLK, HRESET (sync, active-high); descriptor write port i_desc_*;
//        run control i_num_layers, i_base_weight, i_base_param, i_timeout, i_start, i_abort;
//        acc (master modport) carries bases, config, cfg_valid, layer_start and layer_done;
//        status o_busy, o_cur_layer, o_net_done, o_error.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int MAX_LAYER    = 8,
  parameter int W_LIDX       = 4,
  parameter int Ti           = 16,
  parameter int To           = 16,
  parameter int N            = 16,
  parameter int W_WADDR      = 20,
  parameter int W_PADDR      = 12,
  parameter int START_CYCLES = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int W_TMO        = 24
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                i_desc_we,
  input  logic [W_LIDX-1:0]   i_desc_idx,
  input  logic [2:0]          i_desc_act_shift,
  input  logic [4:0]          i_desc_bias_shift,
  input  logic                i_desc_conv3x3,
  input  logic [W_LIDX-1:0]   i_num_layers,
  input  logic [W_WADDR-1:0]  i_base_weight,
  input  logic [W_PADDR-1:0]  i_base_param,
  input  logic [W_TMO-1:0]    i_timeout,
  input  logic                i_start,
  input  logic                i_abort,
  cnn_layer_sequencer_if.master acc,
  output logic                o_busy,
  output logic [W_LIDX-1:0]   o_cur_layer,
  output logic                o_net_done,
  output logic                o_error
);

  localparam logic [W_WADDR-1:0] W_INC_3X3  = W_WADDR'(conv3x3_weight_inc(Ti, To, N));
  localparam logic [W_WADDR-1:0] W_INC_1X1  = W_WADDR'(conv1x1_weight_inc(To));
  localparam logic [W_PADDR-1:0] P_INC      = W_PADDR'(To);
  localparam logic [W_TMO-1:0]   START_LAST = W_TMO'(START_CYCLES - 1);
  localparam logic [W_TMO-1:0]   GAP_LAST   = (GAP_CYCLES > 0) ? W_TMO'(GAP_CYCLES - 1) : '0;
  localparam logic [W_LIDX-1:0]  MAX_NUM    = W_LIDX'(MAX_LAYER);
  localparam logic [W_LIDX-1:0]  ONE_L      = W_LIDX'(1);

  state_t               state, state_nxt;
  logic [W_LIDX-1:0]    lidx, lidx_nxt;
  logic [W_LIDX-1:0]    num, num_nxt;
  logic [W_WADDR-1:0]   bw, bw_nxt;
  logic [W_PADDR-1:0]   bp, bp_nxt;
  logic                 err, err_nxt;
  logic [W_TMO-1:0]     cnt;
  logic [31:0]          cfg;
  logic                 done_q, done_qq;
  logic                 done_edge;
  logic [DESC_W-1:0]    desc_rd;
  logic [W_LIDX-1:0]    num_clamp;

  cnn_seq_desc_ram #(
    .MAX_LAYER (MAX_LAYER),
    .W_LIDX    (W_LIDX),
    .W_DESC    (DESC_W)
  ) u_desc (
    .clk   (HCLK),
    .rst   (HRESET),
    .we    (i_desc_we),
    .waddr (i_desc_idx),
    .wdata ({i_desc_act_shift, i_desc_bias_shift, i_desc_conv3x3}),
    .raddr (lidx_nxt),
    .rdata (desc_rd)
  );

  // A done level left high by the previous layer must not count; only a fresh rise does.
  assign done_edge = done_q & ~done_qq;
  assign num_clamp = (i_num_layers > MAX_NUM) ? MAX_NUM : i_num_layers;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    lidx_nxt           = lidx;
    num_nxt            = num;
    bw_nxt             = bw;
    bp_nxt             = bp;
    err_nxt            = err;
    acc.o_cfg_valid    = 1'b0;
    acc.o_layer_start  = 1'b0;
    o_net_done         = 1'b0;
    o_busy             = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          err_nxt = 1'b0;
          num_nxt = num_clamp;
          if (num_clamp == '0) begin
            state_nxt = ST_FIN;
          end else begin
            state_nxt = ST_LOAD;
            lidx_nxt  = '0;
            bw_nxt    = i_base_weight;
            bp_nxt    = i_base_param;
          end
        end
      end
      ST_LOAD: begin
        o_busy          = 1'b1;
        acc.o_cfg_valid = 1'b1;
        state_nxt       = ST_START;
      end
      ST_START: begin
        o_busy            = 1'b1;
        acc.o_layer_start = 1'b1;
        if (cnt == START_LAST) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        o_busy = 1'b1;
        if (done_edge) begin
          bw_nxt = bw + (cfg[CFG_CONV] ? W_INC_3X3 : W_INC_1X1);
          bp_nxt = bp + P_INC;
          if (lidx == num - ONE_L) begin
            state_nxt = ST_FIN;
          end else begin
            lidx_nxt  = lidx + ONE_L;
            state_nxt = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;
          end
        end else if ((i_timeout != '0) && (cnt + W_TMO'(1) == i_timeout)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        o_busy = 1'b1;
        if (cnt == GAP_LAST) state_nxt = ST_LOAD;
      end
      ST_FIN: begin
        o_net_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // abort wins over a done or timeout seen in the same cycle
    if (i_abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
      lidx_nxt  = lidx;
      bw_nxt    = bw;
      bp_nxt    = bp;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      lidx    <= '0;
      num     <= '0;
      bw      <= '0;
      bp      <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      cfg     <= '0;
      done_q  <= 1'b0;
      done_qq <= 1'b0;
    end else begin
      lidx    <= lidx_nxt;
      num     <= num_nxt;
      bw      <= bw_nxt;
      bp      <= bp_nxt;
      err     <= err_nxt;
      done_q  <= acc.i_layer_done;
      done_qq <= done_q;
      // one counter serves START length, WAIT watchdog and GAP length
      cnt     <= (state_nxt != state) ? '0 : cnt + W_TMO'(1);
      // config is captured on entry to LOAD so it is already stable while o_cfg_valid is high
      if ((state_nxt == ST_LOAD) && (state != ST_LOAD)) begin
        cfg <= build_cfg(desc_rd, 4'(lidx_nxt), lidx_nxt == '0, lidx_nxt == num_nxt - ONE_L);
      end
    end
  end

  assign acc.o_base_weight  = bw;
  assign acc.o_base_param   = bp;
  assign acc.o_layer_config = cfg;
  assign o_cur_layer        = lidx;
  assign o_error            = err;

endmodule
